// File: rtl/peak_detector_pkg.sv
// Shared types for the peak detector slice.
// State encodings used by the search FSM.
package peak_detector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/peak_detector_if.sv
// Sample/control stream in, window result out.
// master = upstream driver, slave = detector.
interface peak_detector_if #(
  parameter int DATA_WIDTH  = 18,
  parameter int INDEX_WIDTH = 10
);

  logic                   start;
  logic                   enable;
  logic [DATA_WIDTH-1:0]  dataIn;
  logic [DATA_WIDTH-1:0]  threshold;
  logic                   busy;
  logic                   done;
  logic                   peakFound;
  logic [DATA_WIDTH-1:0]  peakValue;
  logic [INDEX_WIDTH-1:0] peakIndex;

  modport master (
    output start, enable, dataIn, threshold,
    input  busy, done, peakFound,
    input  peakValue, peakIndex
  );

  modport slave (
    input  start, enable, dataIn, threshold,
    output busy, done, peakFound,
    output peakValue, peakIndex
  );

endinterface

// File: rtl/peak_detector_window_counter.sv
// Accepted-sample counter for one search window.
// last flags the advance that consumes the final slot.
module window_counter #(
  parameter int WINDOW_LENGTH = 1024,
  parameter int INDEX_WIDTH   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   advance,
  output logic [INDEX_WIDTH-1:0] count,
  output logic                   last
);

  localparam logic [INDEX_WIDTH-1:0] LAST_COUNT =
    INDEX_WIDTH'(WINDOW_LENGTH - 1);

  assign last = advance && (count == LAST_COUNT);

  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (advance)
      count <= last ? '0 : count + INDEX_WIDTH'(1);
  end

endmodule

// File: rtl/peak_detector.sv
// Windowed peak search over an unsigned magnitude stream.
// Result registers update together with the done pulse.
module peak_detector #(
  parameter int DATA_WIDTH    = 18,
  parameter int WINDOW_LENGTH = 1024,
  parameter int INDEX_WIDTH   = 10
) (
  input  logic          clock,
  input  logic          reset,
  peak_detector_if.slave bus
);

  import peak_detector_pkg::*;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  thr;
  logic [DATA_WIDTH-1:0]  max_int;
  logic [INDEX_WIDTH-1:0] idx_int;
  logic                   found_int;

  logic [DATA_WIDTH-1:0]  max_nxt;
  logic [INDEX_WIDTH-1:0] idx_nxt;
  logic                   found_nxt;

  logic [INDEX_WIDTH-1:0] count;
  logic                   last;
  logic                   accept;
  logic                   open;
  logic                   hit;

  assign accept = (state == SEARCH) && bus.enable;
  assign open   = bus.start &&
                  (state == IDLE || state == REPORT);

  window_counter #(
    .WINDOW_LENGTH (WINDOW_LENGTH),
    .INDEX_WIDTH   (INDEX_WIDTH)
  ) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (open),
    .advance (accept),
    .count   (count),
    .last    (last)
  );

  // Strict > keeps the earliest index on ties.
  always_comb begin
    hit = (bus.dataIn >= thr) &&
          (!found_int || bus.dataIn > max_int);
    max_nxt   = max_int;
    idx_nxt   = idx_int;
    found_nxt = found_int;
    if (hit) begin
      max_nxt   = bus.dataIn;
      idx_nxt   = count;
      found_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      thr           <= '0;
      max_int       <= '0;
      idx_int       <= '0;
      found_int     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.peakFound <= 1'b0;
      bus.peakValue <= '0;
      bus.peakIndex <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: ;
        SEARCH: begin
          if (accept) begin
            max_int   <= max_nxt;
            idx_int   <= idx_nxt;
            found_int <= found_nxt;
            if (last) begin
              state         <= REPORT;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              bus.peakFound <= found_nxt;
              bus.peakValue <= max_nxt;
              bus.peakIndex <= idx_nxt;
            end
          end
        end
        REPORT: begin
          if (!bus.start)
            state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
      if (open) begin
        state     <= SEARCH;
        bus.busy  <= 1'b1;
        thr       <= bus.threshold;
        max_int   <= '0;
        idx_int   <= '0;
        found_int <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peak_detector.sv
// Randomized scoreboard bench for peak_detector.
// Window of 8 samples, 3-bit index, 18-bit data.
module tb_peak_detector;

  localparam int DW = 18;
  localparam int WL = 8;
  localparam int IW = 3;

  typedef logic [DW-1:0] win_t [WL];
  typedef struct {
    logic [DW-1:0] val;
    logic [IW-1:0] idx;
    logic          found;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t held = '{default: 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  peak_detector_if #(
    .DATA_WIDTH  (DW),
    .INDEX_WIDTH (IW)
  ) bus ();

  peak_detector #(
    .DATA_WIDTH    (DW),
    .WINDOW_LENGTH (WL),
    .INDEX_WIDTH   (IW)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Reference: peak = max of the qualifying samples,
  // index = first position holding that value.
  function automatic exp_t model(input logic [DW-1:0] t,
                                 input win_t v);
    exp_t e;
    logic [DW-1:0] mx;
    bit any;
    mx = '0;
    any = 0;
    foreach (v[i])
      if (v[i] >= t) begin
        any = 1;
        if (v[i] > mx) mx = v[i];
      end
    e.found = any;
    e.val = any ? mx : '0;
    e.idx = '0;
    e.cyc = 0;
    if (any)
      for (int i = WL - 1; i >= 0; i--)
        if (v[i] == mx) e.idx = IW'(i);
    return e;
  endfunction

  task automatic do_start(input logic [DW-1:0] t);
    @(negedge clk);
    bus.start = 1'b1;
    bus.threshold = t;
    bus.enable = 1'($urandom_range(0, 1));
    bus.dataIn = '1;
  endtask

  // stall: 0 none, 1 one idle cycle between samples, 2 random gaps
  task automatic feed(input logic [DW-1:0] t, input win_t v,
                      input int n, input int stall,
                      input bit chain, input logic [DW-1:0] nthr);
    int gaps;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      gaps = (i == 0) ? 0 :
             (stall == 1) ? 1 :
             (stall == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        bus.start = 1'($urandom_range(0, 1));
        bus.enable = 1'b0;
        bus.dataIn = '1;
        bus.threshold = DW'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.enable = 1'b1;
      bus.dataIn = v[i];
      bus.threshold = DW'($urandom);
      if (i == 0) check("busy_search", 64'(bus.busy), 64'd1);
      if (i == WL - 1) begin
        e = model(t, v);
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end
    if (n == WL) begin
      @(negedge clk);
      bus.enable = 1'($urandom_range(0, 1));
      bus.dataIn = '1;
      bus.start = chain;
      bus.threshold = nthr;
    end
  endtask

  function automatic win_t rand_win();
    win_t v;
    logic [DW-1:0] pool [4];
    foreach (pool[k]) begin
      case ($urandom_range(0, 7))
        0: pool[k] = 18'h20000;
        1: pool[k] = 18'h3FFFF;
        default: pool[k] = DW'($urandom_range(0, 400));
      endcase
    end
    foreach (v[i]) v[i] = pool[$urandom_range(0, 3)];
    return v;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("peak_value", 64'(bus.peakValue), 64'(e.val));
          check("peak_index", 64'(bus.peakIndex), 64'(e.idx));
          check("peak_found", 64'(bus.peakFound), 64'(e.found));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          held = e;
        end
      end else begin
        check("hold",
              64'({bus.peakFound, bus.peakValue, bus.peakIndex}),
              64'({held.found, held.val, held.idx}));
      end
    end
  end

  initial begin : main
    win_t t1, t2, t3, t4, t5, v;
    logic [DW-1:0] thr, nthr;
    bit chained, ch;
    exp_t e;
    t1 = '{18'd5, 18'd20, 18'd300, 18'd7,
           18'd150, 18'd0, 18'd9, 18'd1};
    t2 = '{default: 18'd999};
    t3 = '{18'd50, 18'd80, 18'd80, 18'd80,
           18'd10, 18'd10, 18'd10, 18'd10};
    t4 = '{default: 18'h1FFFF};
    t4[6] = 18'h20000;
    t5 = '{18'd1, 18'd2, 18'd3, 18'd4,
           18'd5, 18'd6, 18'd7, 18'd42};
    bus.start = 1'b0;
    bus.enable = 1'b0;
    bus.dataIn = '0;
    bus.threshold = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_found", 64'(bus.peakFound), 64'd0);
    check("rst_value", 64'(bus.peakValue), 64'd0);
    check("rst_index", 64'(bus.peakIndex), 64'd0);
    rst = 1'b0;

    do_start(18'd100);  feed(18'd100, t1, WL, 0, 0, '0);
    do_start(18'd1000); feed(18'd1000, t2, WL, 2, 0, '0);
    do_start(18'd0);    feed(18'd0, t3, WL, 1, 0, '0);
    do_start(18'd0);    feed(18'd0, t4, WL, 2, 0, '0);
    do_start(18'd100);  feed(18'd100, t1, WL, 0, 1, 18'd0);
    feed(18'd0, t5, WL, 2, 0, '0);

    do_start(18'd100);
    feed(18'd100, t1, 4, 0, 0, '0);
    @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.start = 1'b0;
    held = '{default: 0};
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_out",
          64'({bus.peakFound, bus.peakValue, bus.peakIndex}),
          64'd0);
    do_start(18'd100); feed(18'd100, t1, WL, 0, 0, '0);

    chained = 0;
    thr = DW'($urandom_range(0, 300));
    for (int w = 0; w < 24; w++) begin
      v = rand_win();
      if (!chained) do_start(thr);
      nthr = DW'($urandom_range(0, 300));
      ch = (w < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      feed(thr, v, WL, int'($urandom_range(0, 2)), ch, nthr);
      chained = ch;
      thr = nthr;
    end

    @(negedge clk);
    bus.start = 1'b0;
    bus.enable = 1'b0;
    for (int k = 0; k < 20 && sb.size() > 0; k++)
      @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("missing_done", 64'd0, 64'd1);
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
